// File: rtl/fir_ram_arbiter_if.sv
// Shared-RAM bus between the host port, the FIR read port and the RAM itself.
//   Host   : h_req/h_we/h_addr/h_wdata in, h_gnt/h_stall/h_rvalid/h_rdata out
//   FIR    : f_req/f_addr in, f_gnt/f_rvalid/f_rdata out, pracuje (FIR busy)
//   RAM    : ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in (1-cycle read latency)
// slave  = arbiter view, master = requesters plus RAM model view.
interface fir_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_stall;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              pracuje;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  h_req, h_we, h_addr, h_wdata, f_req, f_addr, pracuje, ram_rdata,
    output h_gnt, h_stall, h_rvalid, h_rdata, f_gnt, f_rvalid, f_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output h_req, h_we, h_addr, h_wdata, f_req, f_addr, pracuje, ram_rdata,
    input  h_gnt, h_stall, h_rvalid, h_rdata, f_gnt, f_rvalid, f_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fir_ram_arbiter.sv
// Arbiter sharing one single-port sample/coefficient RAM between a host port
// and the FIR datapath read port. One access per cycle, grants are
// combinational; read data returns one cycle later on the side that issued it.
// While pracuje=1 the FIR has priority, bounded by MAX_WAIT refusals of the
// host; otherwise the two sides round-robin.
// Ports: clk, rst (sync, active-high), bus (fir_ram_arbiter_if.slave).
module fir_ram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input logic              clk,
  input logic              rst,
  fir_ram_arbiter_if.slave bus
);

  typedef enum logic {LAST_H = 1'b0, LAST_F = 1'b1} owner_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  owner_t            last_owner;
  logic [7:0]        wait_cnt;
  logic              host_first;
  logic              h_gnt_c;
  logic              f_gnt_c;
  logic              rd_vld_p1;
  owner_t            rd_own_p1;
  logic              h_rvalid_c;
  logic              f_rvalid_c;
  logic [DATA_W-1:0] h_rdata_q;
  logic [DATA_W-1:0] f_rdata_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 8'd1;
  endfunction

  // ---- stage p0: arbitration and RAM drive (combinational) ----
  always_comb begin
    host_first = bus.pracuje ? (wait_cnt == MAX_WAIT_C) : (last_owner == LAST_F);
    // rst gates every grant so a read issued during reset never returns data
    h_gnt_c = ~rst & bus.h_req & (~bus.f_req | host_first);
    f_gnt_c = ~rst & bus.f_req & ~h_gnt_c;
  end

  assign bus.h_gnt     = h_gnt_c;
  assign bus.f_gnt     = f_gnt_c;
  assign bus.h_stall   = ~rst & bus.h_req & ~h_gnt_c;
  assign bus.ram_en    = h_gnt_c | f_gnt_c;
  assign bus.ram_we    = h_gnt_c & bus.h_we;
  assign bus.ram_addr  = h_gnt_c ? bus.h_addr : (f_gnt_c ? bus.f_addr : '0);
  assign bus.ram_wdata = h_gnt_c ? bus.h_wdata : '0;

  // ---- stage p1: read return steered by the registered tag ----
  assign h_rvalid_c   = ~rst & rd_vld_p1 & (rd_own_p1 == LAST_H);
  assign f_rvalid_c   = ~rst & rd_vld_p1 & (rd_own_p1 == LAST_F);
  assign bus.h_rvalid = h_rvalid_c;
  assign bus.f_rvalid = f_rvalid_c;
  // Returning side sees RAM data directly; the other side holds its last value
  assign bus.h_rdata  = rst ? '0 : (h_rvalid_c ? bus.ram_rdata : h_rdata_q);
  assign bus.f_rdata  = rst ? '0 : (f_rvalid_c ? bus.ram_rdata : f_rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= LAST_F;
      wait_cnt   <= 8'd0;
      rd_vld_p1  <= 1'b0;
      rd_own_p1  <= LAST_F;
      h_rdata_q  <= '0;
      f_rdata_q  <= '0;
    end else begin
      if (h_gnt_c)      last_owner <= LAST_H;
      else if (f_gnt_c) last_owner <= LAST_F;
      wait_cnt  <= (bus.h_req & ~h_gnt_c) ? sat_inc(wait_cnt) : 8'd0;
      rd_vld_p1 <= f_gnt_c | (h_gnt_c & ~bus.h_we);
      rd_own_p1 <= h_gnt_c ? LAST_H : LAST_F;
      if (h_rvalid_c) h_rdata_q <= bus.ram_rdata;
      if (f_rvalid_c) f_rdata_q <= bus.ram_rdata;
    end
  end

endmodule

// File: tb/tb_fir_ram_arbiter.sv
// Bench for fir_ram_arbiter: directed vector table, hand sequences for the
// priority-timeout and mode-switch cases, then randomized traffic against a
// behavioural model with a shadow memory.
module tb_fir_ram_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 15;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fir_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fir_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(16'hA000 + i);
  endfunction

  // RAM model: reloads known contents on reset, 1-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pr, input logic hr, input logic hw,
                       input logic [ADDR_W-1:0] ha, input logic [DATA_W-1:0] hd,
                       input logic fr, input logic [ADDR_W-1:0] fa);
    @(posedge clk);
    #1;
    rst         = r;
    bus.pracuje = pr;
    bus.h_req   = hr;
    bus.h_we    = hw;
    bus.h_addr  = ha;
    bus.h_wdata = hd;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    @(negedge clk);
  endtask

  typedef struct {
    logic              rst, pr, hr, hw;
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;
    logic              fr;
    logic [ADDR_W-1:0] fa;
    logic              e_hg, e_fg, e_hv, e_fv;
    logic [DATA_W-1:0] e_hrd, e_frd;
  } vec_t;

  vec_t tbl [12];

  // behavioural model state for the random phase
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              m_last_f;
  int                m_refused;
  logic              pend_vld, pend_h;
  logic [DATA_W-1:0] pend_data, m_hrd, m_frd;

  initial begin
    logic       hg, fg, stall;
    logic       e_hg, e_fg, e_hv, e_fv, e_st, e_en, e_we, host_first;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e_hrd, e_frd;
    logic       hold_h, hold_f, pr, r;
    logic       hr, hw, fr;
    logic [ADDR_W-1:0] ha, fa;
    logic [DATA_W-1:0] hd;

    //            rst pr hr hw ha       hd        fr fa        hg fg hv fv hrd       frd
    tbl[0]  = '{1, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{0, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 1, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 0, 1, 1, 0, 16'hA010, 16'h0000};
    tbl[3]  = '{0, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 1, 0, 0, 1, 16'hA010, 16'hA011};
    tbl[4]  = '{0, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 0, 1, 1, 0, 16'hA010, 16'hA011};
    tbl[5]  = '{0, 0, 1, 1, 10'h005, 16'h1234, 0, 10'h000, 1, 0, 0, 1, 16'hA010, 16'hA011};
    tbl[6]  = '{0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h005, 0, 1, 0, 0, 16'hA010, 16'hA011};
    tbl[7]  = '{0, 0, 0, 0, 10'h000, 16'h0000, 0, 10'h000, 0, 0, 0, 1, 16'hA010, 16'h1234};
    tbl[8]  = '{0, 0, 1, 0, 10'h011, 16'h0000, 0, 10'h000, 1, 0, 0, 0, 16'hA010, 16'h1234};
    tbl[9]  = '{1, 0, 1, 0, 10'h011, 16'h0000, 1, 10'h011, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[10] = '{0, 0, 1, 0, 10'h010, 16'h0000, 1, 10'h011, 1, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[11] = '{0, 0, 0, 0, 10'h000, 16'h0000, 0, 10'h000, 0, 0, 1, 0, 16'hA010, 16'h0000};

    drive(1, 0, 0, 0, '0, '0, 0, '0);

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].pr, tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd,
            tbl[i].fr, tbl[i].fa);
      e_st = tbl[i].hr & ~tbl[i].e_hg & ~tbl[i].rst;
      check($sformatf("tbl%0d ctl{hg,fg,hv,fv,stall}", i),
            {27'd0, bus.h_gnt, bus.f_gnt, bus.h_rvalid, bus.f_rvalid, bus.h_stall},
            {27'd0, tbl[i].e_hg, tbl[i].e_fg, tbl[i].e_hv, tbl[i].e_fv, e_st});
      check($sformatf("tbl%0d rdata{h,f}", i), {bus.h_rdata, bus.f_rdata},
            {tbl[i].e_hrd, tbl[i].e_frd});
      if (tbl[i].rst)
        check($sformatf("tbl%0d ram in reset", i),
              {bus.ram_en, bus.ram_we, 4'd0, bus.ram_addr, bus.ram_wdata}, 32'd0);
    end

    // ---- FIR priority with host timeout: 15 F grants then one H ----
    drive(1, 1, 0, 0, '0, '0, 0, '0);
    for (int k = 0; k < 34; k++) begin
      drive(0, 1, 1, 0, ADDR_W'(k), '0, 1, ADDR_W'(k + 1));
      e_hg = ((k % 16) == 15);
      check($sformatf("prio k=%0d {hg,fg,stall}", k),
            {29'd0, bus.h_gnt, bus.f_gnt, bus.h_stall}, {29'd0, e_hg, ~e_hg, ~e_hg});
    end

    // ---- pracuje 1->0 with wait_cnt=7: round-robin applies at once ----
    drive(1, 1, 0, 0, '0, '0, 0, '0);
    for (int k = 0; k < 9; k++) begin
      pr = (k < 7);
      drive(0, pr, 1, 0, 10'h020, '0, 1, 10'h021);
      e_hg = (k == 7);
      check($sformatf("switch k=%0d {hg,fg}", k), {30'd0, bus.h_gnt, bus.f_gnt},
            {30'd0, e_hg, ~e_hg});
    end

    // ---- randomized traffic against behavioural model ----
    drive(1, 0, 0, 0, '0, '0, 0, '0);
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    m_last_f = 1'b1; m_refused = 0; pend_vld = 1'b0; pend_h = 1'b0;
    pend_data = '0; m_hrd = '0; m_frd = '0;
    hold_h = 1'b0; hold_f = 1'b0; pr = 1'b0;
    hr = 0; hw = 0; ha = '0; hd = '0; fr = 0; fa = '0;

    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) pr = ~pr;
      if (!hold_h) begin
        hr = $urandom_range(0, 1) == 1;
        hw = $urandom_range(0, 2) == 0;
        ha = ADDR_W'($urandom_range(0, 15));
        hd = DATA_W'($urandom);
      end
      if (!hold_f) begin
        fr = $urandom_range(0, 1) == 1;
        fa = ADDR_W'($urandom_range(0, 15));
      end
      drive(r, pr, hr, hw, ha, hd, fr, fa);

      if (r) begin
        {e_hg, e_fg, e_hv, e_fv, e_st, e_en, e_we} = '0;
        e_addr = '0; e_wd = '0; e_hrd = '0; e_frd = '0;
      end else begin
        host_first = pr ? (m_refused >= MAX_WAIT) : m_last_f;
        e_hg   = hr && (!fr || host_first);
        e_fg   = fr && !e_hg;
        e_st   = hr && !e_hg;
        e_en   = e_hg || e_fg;
        e_we   = e_hg && hw;
        e_addr = e_hg ? ha : (e_fg ? fa : '0);
        e_wd   = e_hg ? hd : '0;
        e_hv   = pend_vld && pend_h;
        e_fv   = pend_vld && !pend_h;
        e_hrd  = e_hv ? pend_data : m_hrd;
        e_frd  = e_fv ? pend_data : m_frd;
      end

      hg = bus.h_gnt; fg = bus.f_gnt; stall = bus.h_stall;
      check($sformatf("rnd%0d ctl{hg,fg,hv,fv,stall,en,we}", c),
            {25'd0, hg, fg, bus.h_rvalid, bus.f_rvalid, stall, bus.ram_en, bus.ram_we},
            {25'd0, e_hg, e_fg, e_hv, e_fv, e_st, e_en, e_we});
      check($sformatf("rnd%0d ram{addr,wdata}", c), {6'd0, bus.ram_addr, bus.ram_wdata},
            {6'd0, e_addr, e_wd});
      check($sformatf("rnd%0d rdata{h,f}", c), {bus.h_rdata, bus.f_rdata}, {e_hrd, e_frd});

      if (r) begin
        m_last_f = 1'b1; m_refused = 0; pend_vld = 1'b0; m_hrd = '0; m_frd = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
        hold_h = 1'b0; hold_f = 1'b0;
      end else begin
        if (e_hg)      m_last_f = 1'b0;
        else if (e_fg) m_last_f = 1'b1;
        m_refused = (hr && !e_hg) ? ((m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1) : 0;
        m_hrd     = e_hrd;
        m_frd     = e_frd;
        pend_vld  = e_fg || (e_hg && !hw);
        pend_h    = e_hg;
        pend_data = e_hg ? shadow[ha] : shadow[fa];
        if (e_hg && hw) shadow[ha] = hd;
        hold_h = hr && !e_hg;
        hold_f = fr && !e_fg;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_ram_arbiter.md
FIR_RAM_ARBITER -- requirements
Module: fir_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, address width of the shared sample/coefficient RAM.
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 Parameter MAX_WAIT, default 15, maximum consecutive cycles a pending host request may be refused while the FIR has priority; range 1..255.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 h_req  in  1  host access request; held until h_gnt.
REQ-007 h_we  in  1  host write (1) / read (0); qualified by h_req.
REQ-008 h_addr  in  ADDR_W  host address.
REQ-009 h_wdata  in  DATA_W  host write data.
REQ-010 h_gnt  out  1  host access accepted this cycle.
REQ-011 h_rvalid  out  1  host read data valid.
REQ-012 h_rdata  out  DATA_W  host read data.
REQ-013 f_req  in  1  FIR datapath read request; held until f_gnt.
REQ-014 f_addr  in  ADDR_W  FIR read address.
REQ-015 f_gnt  out  1  FIR access accepted this cycle.
REQ-016 f_rvalid  out  1  FIR read data valid.
REQ-017 f_rdata  out  DATA_W  FIR read data.
REQ-018 pracuje  in  1  FIR sequencer busy; selects FIR-priority mode.
REQ-019 ram_en  out  1  RAM access strobe.
REQ-020 ram_we  out  1  RAM write enable.
REQ-021 ram_addr  out  ADDR_W  RAM address.
REQ-022 ram_wdata  out  DATA_W  RAM write data.
REQ-023 ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.
REQ-024 h_stall  out  1  host request refused this cycle (h_req=1, h_gnt=0).

Function
REQ-025 At most one of h_gnt, f_gnt SHALL be 1 in any cycle; grants are combinational from current requests and registered state.
REQ-026 A grant SHALL drive the RAM in the same cycle: ram_en=1, ram_addr=granted address, ram_we=h_we for host / 0 for FIR, ram_wdata=h_wdata for host / 0 for FIR (0 also when idle).
REQ-027 With no grant, ram_en, ram_we SHALL be 0 and ram_addr SHALL be 0.
REQ-028 Registered arbitration state last_owner in {LAST_H, LAST_F}; updated to the granted side on every grant, held otherwise.
REQ-029 Mode PRIO (pracuje=1): FIR SHALL win when both request, unless wait_cnt==MAX_WAIT, in which case host SHALL win that cycle.
REQ-030 Mode RR (pracuje=0): both requesting -> grant side opposite to last_owner; single requester always granted.
REQ-031 wait_cnt (8 bit) SHALL increment when h_req=1 and h_gnt=0, saturate at MAX_WAIT, clear to 0 on h_gnt or h_req=0.
REQ-032 Read return: a registered tag SHALL record {valid, owner} of a granted read; next cycle exactly one of h_rvalid/f_rvalid SHALL be 1 with the matching rdata = ram_rdata.
REQ-033 Writes SHALL produce no rvalid; non-selected rdata output SHALL hold its last value.
REQ-034 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle); read return for cycle N coexists with grant in cycle N+1.
REQ-035 pracuje changing mid-stream SHALL take effect the same cycle; in-flight read returns are unaffected.
REQ-036 h_stall SHALL equal h_req & ~h_gnt.

Reset
REQ-037 While rst=1: last_owner=LAST_F, wait_cnt=0, read tag invalid; h_gnt, f_gnt, h_rvalid, f_rvalid, ram_en, ram_we, h_stall =0; ram_addr, ram_wdata, h_rdata, f_rdata =0.
REQ-038 A read granted in the cycle rst asserts SHALL NOT produce rvalid after reset; first grant possible in the first cycle with rst=0.

Verification
REQ-039 pracuje=0, both req continuously from reset -> grants alternate H,F,H,F starting with H.
REQ-040 pracuje=1, MAX_WAIT=15, f_req and h_req held -> 15 F grants, h_stall=1 for 15 cycles, H grant on cycle 16, wait_cnt=0, then F again.
REQ-041 Host write addr 0x005 data 0x1234, then FIR read addr 0x005 -> f_rvalid one cycle after f_gnt, f_rdata=0x1234, h_rvalid stays 0.
REQ-042 Alternating host read / FIR read every cycle -> each rvalid lands on the correct side with its own address's data, no bubble.
REQ-043 Assert rst during a granted read -> no rvalid follows; all outputs 0; next arbitration in RR starts with H.
REQ-044 Toggle pracuje 1->0 with wait_cnt=7 and both requesting -> RR rule applies immediately from last_owner.
